kd_sort_ctrl: RTL
=================

KD_SORT_CTRL -- requirements
Module: kd_sort_ctrl

Interface
REQ-001 Parameters SHALL be: dim, default 3, point dimensionality; data_range, default 255, max coordinate value; LEVELS, default 3, tree depth; NODES = 2**LEVELS-1 (derived, not overridable).
REQ-002 clk  in  1  rising-edge clock; one clock domain only.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  one-cycle pulse that begins a sort run; ignored unless in IDLE.
REQ-005 stable_vec  in  NODES  per-CE stable flags, bit i = heap node i.
REQ-006 pt_valid / pt_ready  in / out  1 each  query-point handshake; transfer on valid&&ready.
REQ-007 dist_done  in  1  distance unit finished for the current level.
REQ-008 send_left, send_right  in  1 each  branch decision of the CE at node_idx.
REQ-009 en, sorting, point_prop  out  1 each  CE mode controls.
REQ-010 ce_mask  out  NODES  per-CE enable for the current phase.
REQ-011 axis  out  $clog2(dim)  split axis = level mod dim.
REQ-012 node_idx  out  $clog2(NODES+1)  heap index of the node being queried.
REQ-013 busy, sorted, q_done, other_seen  out  1 each  status flags.

Function
REQ-014 FSM states SHALL be IDLE, SORT_EVEN, SORT_ODD, QWAIT, QWALK, QDONE.
REQ-015 IDLE + start SHALL go to SORT_EVEN next cycle, clear sorted, set busy.
REQ-016 SORT_EVEN SHALL assert en=sorting=1, ce_mask = nodes on even levels (level 0 = root); SORT_ODD the same for odd levels; each phase lasts exactly one cycle.
REQ-017 At the end of each phase the controller SHALL sample (stable_vec | ~ce_mask); all-ones sets the phase-stable bit, otherwise clears it.
REQ-018 After SORT_ODD, if both phase-stable bits are set, go to QWAIT with sorted=1; otherwise return to SORT_EVEN.
REQ-019 QWAIT SHALL assert pt_ready=1; on transfer, set node_idx=0, level=0, enter QWALK; no query is accepted in any other state.
REQ-020 QWALK SHALL assert en=point_prop=1, ce_mask one-hot at node_idx, and hold until dist_done.
REQ-021 On dist_done: send_left only -> node_idx=2*i+1; send_right only -> 2*i+2; both -> left, set other_seen (sticky per query); neither -> QDONE; level increments.
REQ-022 When level reaches LEVELS-1 and dist_done is seen, the FSM SHALL go to QDONE without updating node_idx.
REQ-023 QDONE SHALL pulse q_done for one cycle, then return to QWAIT; sorted stays 1.
REQ-024 start asserted while busy SHALL be ignored; start in QWAIT SHALL re-enter SORT_EVEN (re-sort).
REQ-025 Outside SORT_*/QWALK, en, sorting, point_prop and ce_mask SHALL be 0.
REQ-026 sorting and point_prop SHALL never be 1 in the same cycle.

Reset
REQ-027 rst low SHALL immediately force IDLE, all outputs 0, node_idx=0, level=0, phase-stable bits 0, other_seen 0, including mid-sort and mid-query.

Configuration
REQ-028 With KD_SORT_TIMEOUT_EN defined: an 8-bit round counter SHALL count SORT_ODD completions; on reaching 255 without convergence the FSM SHALL go to IDLE and assert output timeout_err (sticky until next start). Without it: no counter, no timeout_err port, sorting loops until converged.

Structure
REQ-029 Package kd_pkg SHALL hold the state enum, and the dist_size/dim_size/center_size/axis_size derivations shared with cluster_CE.
REQ-030 One sub-module, kd_level_mask, SHALL generate the even/odd level masks and the one-hot node mask from LEVELS.

Verification
REQ-031 All stable_vec=1, start -> SORT_EVEN, SORT_ODD, QWAIT with sorted=1 at cycle 3.
REQ-032 stable_vec bit 0 low for 2 rounds, then high -> exactly 3 even/odd rounds before sorted=1.
REQ-033 Query with send_left=1 at every level, LEVELS=3 -> node_idx 0->1->3, q_done one cycle after the third dist_done.
REQ-034 send_left=send_right=1 at root -> node_idx=1, other_seen=1; neither at root -> QDONE at node 0.
REQ-035 rst low during QWALK -> all outputs 0 asynchronously; start after release sorts normally.
REQ-036 With KD_SORT_TIMEOUT_EN defined, stable_vec=0 held -> timeout_err=1 after 255 rounds, FSM in IDLE.

Source files
------------

// File: rtl/kd_sort_ctrl_pkg.sv
// Shared state encoding and width derivations for the kd-tree sort controller and cluster_CE.
package kd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SORT_EVEN = 3'd1,
        ST_SORT_ODD  = 3'd2,
        ST_QWAIT     = 3'd3,
        ST_QWALK     = 3'd4,
        ST_QDONE     = 3'd5
    } kd_state_e;

    // Never return a zero width, even for degenerate parameter values.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int dim_size(input int dim);
        return clog2_min1(dim);
    endfunction

    function automatic int axis_size(input int dim);
        return clog2_min1(dim);
    endfunction

    function automatic int center_size(input int data_range);
        return clog2_min1(data_range + 1);
    endfunction

    // Sum of dim squared coordinate differences.
    function automatic int dist_size(input int dim, input int data_range);
        return 2 * center_size(data_range) + dim_size(dim);
    endfunction

    function automatic int node_level(input int node);
        int lvl;
        lvl = 0;
        while (((1 << (lvl + 1)) - 1) <= node) lvl++;
        return lvl;
    endfunction

endpackage

// File: rtl/kd_sort_ctrl_if.sv
// Query handshake and CE mode-control bundle between the sort controller and the CE array.
interface kd_sort_ctrl_if
    import kd_pkg::*;
#(
    parameter int dim    = 3,
    parameter int LEVELS = 3
);
    localparam int NODES = 2**LEVELS - 1;
    localparam int NW    = $clog2(NODES + 1);
    localparam int AW    = axis_size(dim);

    logic             pt_valid;
    logic             pt_ready;
    logic             dist_done;
    logic             send_left;
    logic             send_right;
    logic             en;
    logic             sorting;
    logic             point_prop;
    logic [NODES-1:0] ce_mask;
    logic [AW-1:0]    axis;
    logic [NW-1:0]    node_idx;

    modport master (
        input  pt_valid, dist_done, send_left, send_right,
        output pt_ready, en, sorting, point_prop, ce_mask, axis, node_idx
    );

    modport slave (
        output pt_valid, dist_done, send_left, send_right,
        input  pt_ready, en, sorting, point_prop, ce_mask, axis, node_idx
    );

endinterface

// File: rtl/kd_sort_ctrl_level_mask.sv
// Static even/odd heap-level masks and the one-hot mask of the node being queried.
module kd_level_mask
    import kd_pkg::*;
#(
    parameter  int LEVELS = 3,
    localparam int NODES  = 2**LEVELS - 1,
    localparam int NW     = $clog2(NODES + 1)
) (
    input  logic [NW-1:0]    node_idx,
    output logic [NODES-1:0] even_mask,
    output logic [NODES-1:0] odd_mask,
    output logic [NODES-1:0] onehot
);

    for (genvar i = 0; i < NODES; i++) begin : g_node
        assign even_mask[i] = (node_level(i) % 2) == 0;
        assign odd_mask[i]  = (node_level(i) % 2) == 1;
        assign onehot[i]    = node_idx == NW'(i);
    end

endmodule

// File: rtl/kd_sort_ctrl.sv
// Sort/query sequencer for a heap-ordered kd-tree of compare elements.
// Optional round-limit watchdog: define KD_SORT_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for start
// SORT_EVEN | CEs on even levels compare/swap
// SORT_ODD  | CEs on odd levels compare/swap, convergence decided
// QWAIT     | tree sorted, accepting a query point
// QWALK     | query descending, one CE active at node_idx
// QDONE     | one-cycle query-complete pulse
module kd_sort_ctrl
    import kd_pkg::*;
#(
    parameter  int dim        = 3,
    parameter  int data_range = 255,
    parameter  int LEVELS     = 3,
    localparam int NODES      = 2**LEVELS - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NODES-1:0] stable_vec,
    kd_sort_ctrl_if.master   cif,
    output logic             busy,
    output logic             sorted,
    output logic             q_done,
    output logic             other_seen
`ifdef KD_SORT_TIMEOUT_EN
    ,
    output logic             timeout_err
`endif
);

    localparam int NW = $clog2(NODES + 1);
    localparam int AW = axis_size(dim);
    localparam int LW = clog2_min1(LEVELS);

    localparam logic [2:0] S_IDLE      = ST_IDLE;
    localparam logic [2:0] S_SORT_EVEN = ST_SORT_EVEN;
    localparam logic [2:0] S_SORT_ODD  = ST_SORT_ODD;
    localparam logic [2:0] S_QWAIT     = ST_QWAIT;
    localparam logic [2:0] S_QWALK     = ST_QWALK;
    localparam logic [2:0] S_QDONE     = ST_QDONE;

    logic [2:0]       state;
    logic [LW-1:0]    level;
    logic [NW-1:0]    node_idx;
    logic             stable_even;
    logic             stable_odd;
    logic [NODES-1:0] even_mask;
    logic [NODES-1:0] odd_mask;
    logic [NODES-1:0] onehot;
    logic             even_ok;
    logic             odd_ok;
    logic             last_level;
    logic             start_ok;
`ifdef KD_SORT_TIMEOUT_EN
    logic [7:0]       round_cnt;
`endif

    kd_level_mask #(.LEVELS(LEVELS)) u_level_mask (
        .node_idx  (node_idx),
        .even_mask (even_mask),
        .odd_mask  (odd_mask),
        .onehot    (onehot)
    );

    // CEs outside the active phase are treated as stable.
    assign even_ok    = &(stable_vec | ~even_mask);
    assign odd_ok     = &(stable_vec | ~odd_mask);
    assign last_level = level == LW'(LEVELS - 1);
    assign start_ok   = start && (state == S_IDLE || state == S_QWAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            level       <= '0;
            node_idx    <= '0;
            stable_even <= 1'b0;
            stable_odd  <= 1'b0;
            sorted      <= 1'b0;
            other_seen  <= 1'b0;
`ifdef KD_SORT_TIMEOUT_EN
            round_cnt   <= '0;
            timeout_err <= 1'b0;
`endif
        end else if (start_ok) begin
            state       <= S_SORT_EVEN;
            sorted      <= 1'b0;
            stable_even <= 1'b0;
            stable_odd  <= 1'b0;
`ifdef KD_SORT_TIMEOUT_EN
            round_cnt   <= 8'd255;
            timeout_err <= 1'b0;
`endif
        end else begin
            case (state)
                S_SORT_EVEN: begin
                    stable_even <= even_ok;
                    state       <= S_SORT_ODD;
                end
                S_SORT_ODD: begin
                    stable_odd <= odd_ok;
                    if (stable_even && odd_ok) begin
                        state  <= S_QWAIT;
                        sorted <= 1'b1;
                    end
`ifdef KD_SORT_TIMEOUT_EN
                    else if (round_cnt == 8'd1) begin
                        state       <= S_IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        round_cnt <= round_cnt - 8'd1;
                        state     <= S_SORT_EVEN;
                    end
`else
                    else begin
                        state <= S_SORT_EVEN;
                    end
`endif
                end
                S_QWAIT: begin
                    if (cif.pt_valid) begin
                        state      <= S_QWALK;
                        node_idx   <= '0;
                        level      <= '0;
                        other_seen <= 1'b0;
                    end
                end
                S_QWALK: begin
                    if (cif.dist_done) begin
                        if (last_level || !(cif.send_left || cif.send_right)) begin
                            state <= S_QDONE;
                        end else begin
                            level <= level + LW'(1);
                            // Both branches viable: follow left, remember the other side.
                            if (cif.send_left) node_idx <= (node_idx << 1) + NW'(1);
                            else               node_idx <= (node_idx << 1) + NW'(2);
                            if (cif.send_left && cif.send_right) other_seen <= 1'b1;
                        end
                    end
                end
                S_QDONE: state <= S_QWAIT;
                S_IDLE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        cif.en         = 1'b0;
        cif.sorting    = 1'b0;
        cif.point_prop = 1'b0;
        cif.pt_ready   = 1'b0;
        cif.ce_mask    = '0;
        case (state)
            S_SORT_EVEN: begin
                cif.en      = 1'b1;
                cif.sorting = 1'b1;
                cif.ce_mask = even_mask;
            end
            S_SORT_ODD: begin
                cif.en      = 1'b1;
                cif.sorting = 1'b1;
                cif.ce_mask = odd_mask;
            end
            S_QWALK: begin
                cif.en         = 1'b1;
                cif.point_prop = 1'b1;
                cif.ce_mask    = onehot;
            end
            S_QWAIT: cif.pt_ready = 1'b1;
            default: ;
        endcase
    end

    assign busy         = state inside {S_SORT_EVEN, S_SORT_ODD, S_QWALK, S_QDONE};
    assign q_done       = state == S_QDONE;
    assign cif.node_idx = node_idx;
    assign cif.axis     = AW'(int'(level) % dim);

endmodule
